// File: rtl/visualizador_puntos.sv
// Score display: binary-to-BCD (double dabble, saturating at 9999) feeding a
// 4-digit multiplexed common-anode 7-segment display with leading-zero blanking.
module visualizador_puntos #(
  parameter int PRESCALE = 50000
) (
  input  logic        iClk,
  input  logic        iReset,
  input  logic [15:0] iNumero,
  output logic [3:0]  oAnodo,
  output logic [6:0]  oSegmentos,
  output logic        oOcupado
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] SCAN_MAX = CW'(PRESCALE - 1);

  typedef enum logic [1:0] {ESPERA, CONV, CARGA} estado_t;

  estado_t       state_q, state_d;
  logic [15:0]   ultimo_q, ultimo_d;
  logic [13:0]   shift_q, shift_d;
  logic [15:0]   bcd_q, bcd_d;
  logic [3:0]    bits_q, bits_d;
  logic [15:0]   digits_q, digits_d;
  logic [15:0]   bcdAdj;

  logic [CW-1:0] scan_q, scan_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    anodo_q, anodo_d;
  logic [6:0]    seg_q, seg_d;
  logic          wrap;
  logic          blank;

  function automatic logic [6:0] decodificar(input logic [3:0] d, input logic b);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    if (b) s = 7'b1111111;
    return s;
  endfunction

  always_comb begin
    bcdAdj = bcd_q;
    for (int k = 0; k < 4; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) bcdAdj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d  = state_q;
    ultimo_d = ultimo_q;
    shift_d  = shift_q;
    bcd_d    = bcd_q;
    bits_d   = bits_q;
    digits_d = digits_q;
    case (state_q)
      ESPERA: begin
        if (iNumero != ultimo_q) begin
          ultimo_d = iNumero;
          shift_d  = (iNumero > 16'd9999) ? 14'd9999 : iNumero[13:0];
          bcd_d    = '0;
          bits_d   = '0;
          state_d  = CONV;
        end
      end
      CONV: begin
        bcd_d   = {bcdAdj[14:0], shift_q[13]};
        shift_d = {shift_q[12:0], 1'b0};
        bits_d  = bits_q + 4'd1;
        if (bits_q == 4'd13) state_d = CARGA;
      end
      CARGA: begin
        digits_d = bcd_q;
        state_d  = ESPERA;
      end
      default: state_d = ESPERA;
    endcase
  end

  // Segments are decoded for the digit about to be enabled, so anode and
  // segment registers change together on the wrap edge.
  always_comb begin
    wrap    = (scan_q == SCAN_MAX);
    scan_d  = wrap ? '0 : scan_q + 1'b1;
    idx_d   = wrap ? idx_q + 2'd1 : idx_q;
    anodo_d = anodo_q;
    seg_d   = seg_q;
    blank   = 1'b0;
    case (idx_d)
      2'd3:    blank = (digits_q[15:12] == 4'd0);
      2'd2:    blank = (digits_q[15:8] == 8'd0);
      2'd1:    blank = (digits_q[15:4] == 12'd0);
      default: blank = 1'b0;
    endcase
    if (wrap) begin
      anodo_d = ~(4'b0001 << idx_d);
      seg_d   = decodificar(digits_q[4*idx_d +: 4], blank);
    end
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      state_q  <= ESPERA;
      ultimo_q <= '0;
      shift_q  <= '0;
      bcd_q    <= '0;
      bits_q   <= '0;
      digits_q <= '0;
      scan_q   <= '0;
      idx_q    <= '0;
      anodo_q  <= 4'b1110;
      seg_q    <= 7'b1000000;
    end else begin
      state_q  <= state_d;
      ultimo_q <= ultimo_d;
      shift_q  <= shift_d;
      bcd_q    <= bcd_d;
      bits_q   <= bits_d;
      digits_q <= digits_d;
      scan_q   <= scan_d;
      idx_q    <= idx_d;
      anodo_q  <= anodo_d;
      seg_q    <= seg_d;
    end
  end

  assign oAnodo     = anodo_q;
  assign oSegmentos = seg_q;
  assign oOcupado   = (state_q == CONV) || (state_q == CARGA);

endmodule

// File: tb/tb_visualizador_puntos.sv
// Directed bench for visualizador_puntos with a short scan prescale; outputs
// are sampled on the falling clock edge.
module tb_visualizador_puntos;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S6 = 7'b0000010, S7 = 7'b1111000, S9 = 7'b0010000,
                         SB = 7'b1111111;

  logic        iClk = 1'b0;
  logic        iReset = 1'b1;
  logic [15:0] iNumero = 16'd0;
  logic [3:0]  oAnodo;
  logic [6:0]  oSegmentos;
  logic        oOcupado;

  int errors = 0;
  int checks = 0;

  visualizador_puntos #(.PRESCALE(4)) dut (
    .iClk(iClk),
    .iReset(iReset),
    .iNumero(iNumero),
    .oAnodo(oAnodo),
    .oSegmentos(oSegmentos),
    .oOcupado(oOcupado)
  );

  always #5 iClk = ~iClk;

  // Counts busy samples until oOcupado drops; bounded so a stuck DUT still ends.
  task automatic wait_idle(output int n);
    n = 0;
    @(negedge iClk);
    while (oOcupado && n < 100) begin
      n++;
      @(negedge iClk);
    end
    if (n >= 100) begin
      errors++;
      checks++;
      $display("[TB] FAIL busy_timeout: oOcupado still high after %0d cycles", n);
    end
  endtask

  task automatic read_display(output logic [27:0] segs);
    logic [3:0] seen;
    seen = '0;
    segs = '1;
    repeat (16) @(negedge iClk);
    repeat (16) begin
      @(negedge iClk);
      case (oAnodo)
        4'b1110: begin segs[6:0]   = oSegmentos; seen[0] = 1'b1; end
        4'b1101: begin segs[13:7]  = oSegmentos; seen[1] = 1'b1; end
        4'b1011: begin segs[20:14] = oSegmentos; seen[2] = 1'b1; end
        4'b0111: begin segs[27:21] = oSegmentos; seen[3] = 1'b1; end
        default: ;
      endcase
    end
    checks++;
    if (seen !== 4'hF) begin
      errors++;
      $display("[TB] FAIL scan_coverage: digits seen %b, required 1111", seen);
    end
  endtask

  task automatic test_reset();
    logic [1:0] ix;
    logic [3:0] expAn;
    logic [6:0] expSeg;
    iReset  = 1'b1;
    iNumero = 16'd0;
    repeat (3) @(posedge iClk);
    @(negedge iClk);
    iReset = 1'b0;
    for (int j = 0; j < 16; j++) begin
      if (j > 0) @(negedge iClk);
      ix     = 2'(j / 4);
      expAn  = ~(4'b0001 << ix);
      expSeg = (ix == 2'd0) ? S0 : SB;
      checks += 3;
      if (oAnodo !== expAn) begin
        errors++;
        $display("[TB] FAIL reset_anodo[%0d]: got %b, required %b", j, oAnodo, expAn);
      end
      if (oSegmentos !== expSeg) begin
        errors++;
        $display("[TB] FAIL reset_seg[%0d]: got %b, required %b", j, oSegmentos, expSeg);
      end
      if (oOcupado !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_busy[%0d]: got %b, required 0", j, oOcupado);
      end
    end
  endtask

  task automatic test_convert(input string name, input logic [15:0] value,
                              input logic [27:0] expSegs);
    int n;
    logic [27:0] segs;
    iNumero = value;
    wait_idle(n);
    checks++;
    if (n != 15) begin
      errors++;
      $display("[TB] FAIL %s_busy_len: got %0d cycles, required 15", name, n);
    end
    read_display(segs);
    checks++;
    if (segs !== expSegs) begin
      errors++;
      $display("[TB] FAIL %s_display: got %h, required %h", name, segs, expSegs);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int busy;
    logic [3:0] prevAn;
    logic [3:0] seen;
    logic [27:0] segs;
    iNumero = 16'd500;
    repeat (3) @(negedge iClk);
    iNumero = 16'd600;
    n = 0;
    while (oOcupado && n < 100) begin
      n++;
      @(negedge iClk);
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("[TB] FAIL b2b_first_timeout: busy after %0d cycles", n);
    end
    prevAn = oAnodo;
    seen   = '0;
    segs   = '1;
    busy   = 0;
    for (int j = 0; j < 16; j++) begin
      @(negedge iClk);
      if (j == 0) begin
        checks++;
        if (oOcupado !== 1'b1) begin
          errors++;
          $display("[TB] FAIL b2b_restart: oOcupado got %b, required 1", oOcupado);
        end
      end
      if (oOcupado) busy++;
      if (oAnodo !== prevAn) begin
        case (oAnodo)
          4'b1110: begin segs[6:0]   = oSegmentos; seen[0] = 1'b1; end
          4'b1101: begin segs[13:7]  = oSegmentos; seen[1] = 1'b1; end
          4'b1011: begin segs[20:14] = oSegmentos; seen[2] = 1'b1; end
          4'b0111: begin segs[27:21] = oSegmentos; seen[3] = 1'b1; end
          default: ;
        endcase
      end
      prevAn = oAnodo;
    end
    checks += 3;
    if (busy != 15) begin
      errors++;
      $display("[TB] FAIL b2b_busy_len: got %0d cycles, required 15", busy);
    end
    if (seen !== 4'hF) begin
      errors++;
      $display("[TB] FAIL b2b_scan: digits seen %b, required 1111", seen);
    end
    if (segs !== {SB, S5, S0, S0}) begin
      errors++;
      $display("[TB] FAIL b2b_first_value: got %h, required %h", segs, {SB, S5, S0, S0});
    end
    read_display(segs);
    checks++;
    if (segs !== {SB, S6, S0, S0}) begin
      errors++;
      $display("[TB] FAIL b2b_second_value: got %h, required %h", segs, {SB, S6, S0, S0});
    end
  endtask

  task automatic test_reset_mid_conv();
    int n;
    logic [27:0] segs;
    iNumero = 16'd4321;
    repeat (5) @(negedge iClk);
    iReset = 1'b1;
    @(negedge iClk);
    checks += 3;
    if (oAnodo !== 4'b1110) begin
      errors++;
      $display("[TB] FAIL midreset_anodo: got %b, required 1110", oAnodo);
    end
    if (oSegmentos !== S0) begin
      errors++;
      $display("[TB] FAIL midreset_seg: got %b, required %b", oSegmentos, S0);
    end
    if (oOcupado !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_busy: got %b, required 0", oOcupado);
    end
    iReset = 1'b0;
    wait_idle(n);
    checks++;
    if (n != 15) begin
      errors++;
      $display("[TB] FAIL midreset_busy_len: got %0d cycles, required 15", n);
    end
    read_display(segs);
    checks++;
    if (segs !== {S4, S3, S2, S1}) begin
      errors++;
      $display("[TB] FAIL midreset_display: got %h, required %h", segs, {S4, S3, S2, S1});
    end
  endtask

  initial begin
    test_reset();
    test_convert("num1234", 16'd1234, {S1, S2, S3, S4});
    test_convert("sat40000", 16'd40000, {S9, S9, S9, S9});
    test_convert("num7", 16'd7, {SB, SB, SB, S7});
    test_convert("num105", 16'd105, {SB, S1, S0, S5});
    test_back_to_back();
    test_reset_mid_conv();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
